// File: rtl/dualmem_port_ctrl_if.sv
// Bus bundle for dualmem_port_ctrl: the request/response stream plus the RAM port.
//   master : requester side (drives req_*, rsp_ready) and RAM side (drives ram_rddata)
//   slave  : the controller (accepts requests, returns responses, drives the RAM port)
interface dualmem_port_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned LEN_WIDTH  = 4
);
  localparam int unsigned DataWidth = 8 * DATA_BYTES;

  // Request stream
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [DATA_BYTES-1:0] req_be;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic [DataWidth-1:0]  req_wdata;
  // Response stream
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic                  rsp_last;
  logic [DataWidth-1:0]  rsp_rdata;
  // RAM port
  logic                  ram_en;
  logic [DATA_BYTES-1:0] ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DataWidth-1:0]  ram_wrdata;
  logic [DataWidth-1:0]  ram_rddata;

  modport master (
    output req_valid, req_write, req_be, req_addr, req_len, req_wdata, rsp_ready, ram_rddata,
    input  req_ready, rsp_valid, rsp_write, rsp_last, rsp_rdata,
           ram_en, ram_we, ram_addr, ram_wrdata
  );

  modport slave (
    input  req_valid, req_write, req_be, req_addr, req_len, req_wdata, rsp_ready, ram_rddata,
    output req_ready, rsp_valid, rsp_write, rsp_last, rsp_rdata,
           ram_en, ram_we, ram_addr, ram_wrdata
  );
endinterface

// File: rtl/dualmem_port_ctrl.sv
// Port initiator for one port of the 2048x64 byte-writable dual-port RAM.
// Turns single-beat masked writes and incrementing read bursts into RAM cycles, and
// absorbs the RAM's 1-cycle read latency in a 2-entry response FIFO.
// Ports:
//   i_clk   : clock (RAM port clock is the same clock)
//   i_rstn  : synchronous active-low reset
//   io_bus  : request/response stream and RAM port (slave view of dualmem_port_ctrl_if)
module dualmem_port_ctrl #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  dualmem_port_ctrl_if.slave io_bus
);
  localparam int unsigned DataWidth = 8 * DATA_BYTES;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                r_state, w_state_d;
  logic                  r_infl, r_infl_last;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [LEN_WIDTH-1:0]  r_cnt, w_cnt_d;

  // Response FIFO storage; head selected by r_rd_ptr
  logic [DataWidth-1:0]  r_buf_data [2];
  logic [1:0]            r_buf_write, r_buf_last;
  logic                  r_wr_ptr, r_rd_ptr;
  logic [1:0]            r_occ;

  logic                  w_pop, w_credit, w_issue_rd, w_issue_last, w_push_wr, w_slot_b;
  logic [2:0]            w_pending, w_occ_nxt;

  logic                  w_req_ready, w_ram_en;
  logic [DATA_BYTES-1:0] w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DataWidth-1:0]  w_ram_wrdata;

  assign io_bus.rsp_valid  = (r_occ != 2'd0);
  assign io_bus.rsp_write  = r_buf_write[r_rd_ptr];
  assign io_bus.rsp_last   = r_buf_last[r_rd_ptr];
  assign io_bus.rsp_rdata  = r_buf_data[r_rd_ptr];
  assign io_bus.req_ready  = w_req_ready;
  assign io_bus.ram_en     = w_ram_en;
  assign io_bus.ram_we     = w_ram_we;
  assign io_bus.ram_addr   = w_ram_addr;
  assign io_bus.ram_wrdata = w_ram_wrdata;

  assign w_pop     = io_bus.rsp_valid & io_bus.rsp_ready;
  // Slots already committed: buffered entries plus the read returning this cycle
  assign w_pending = {1'b0, r_occ} + {2'b00, r_infl};
  assign w_credit  = w_pending < (3'd2 + {2'b00, w_pop});
  // A write ack accepted alongside returning read data lands behind it
  assign w_slot_b  = r_wr_ptr ^ r_infl;
  assign w_occ_nxt = w_pending + {2'b00, w_push_wr} - {2'b00, w_pop};

  always_comb begin
    w_state_d    = r_state;
    w_addr_d     = r_addr;
    w_cnt_d      = r_cnt;
    w_req_ready  = 1'b0;
    w_ram_en     = 1'b0;
    w_ram_we     = '0;
    w_ram_addr   = '0;
    w_ram_wrdata = '0;
    w_issue_rd   = 1'b0;
    w_issue_last = 1'b0;
    w_push_wr    = 1'b0;
    // Outputs stay quiet while reset is held
    if (i_rstn) begin
      unique case (r_state)
        StIdle: begin
          w_req_ready = w_credit;
          if (io_bus.req_valid && w_credit) begin
            w_ram_en   = 1'b1;
            w_ram_addr = io_bus.req_addr;
            if (io_bus.req_write) begin
              w_ram_we     = io_bus.req_be;
              w_ram_wrdata = io_bus.req_wdata;
              w_push_wr    = 1'b1;
            end else begin
              w_issue_rd   = 1'b1;
              w_issue_last = (io_bus.req_len == '0);
              w_addr_d     = io_bus.req_addr + 1'b1;
              w_cnt_d      = io_bus.req_len;
              if (io_bus.req_len != '0) w_state_d = StBurst;
            end
          end
        end
        StBurst: begin
          if (w_credit) begin
            w_ram_en     = 1'b1;
            w_ram_addr   = r_addr;
            w_issue_rd   = 1'b1;
            w_issue_last = (r_cnt == LEN_WIDTH'(1));
            w_addr_d     = r_addr + 1'b1;
            w_cnt_d      = r_cnt - 1'b1;
            if (r_cnt == LEN_WIDTH'(1)) w_state_d = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state       <= StIdle;
      r_infl        <= 1'b0;
      r_infl_last   <= 1'b0;
      r_addr        <= '0;
      r_cnt         <= '0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_write   <= '0;
      r_buf_last    <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_occ         <= 2'd0;
    end else begin
      assert (w_occ_nxt <= 3'd2);
      r_state     <= w_state_d;
      r_addr      <= w_addr_d;
      r_cnt       <= w_cnt_d;
      r_infl      <= w_issue_rd;
      r_infl_last <= w_issue_last;
      if (r_infl) begin
        r_buf_data[r_wr_ptr]  <= io_bus.ram_rddata;
        r_buf_write[r_wr_ptr] <= 1'b0;
        r_buf_last[r_wr_ptr]  <= r_infl_last;
      end
      if (w_push_wr) begin
        r_buf_data[w_slot_b]  <= '0;
        r_buf_write[w_slot_b] <= 1'b1;
        r_buf_last[w_slot_b]  <= 1'b1;
      end
      r_wr_ptr <= r_wr_ptr ^ r_infl ^ w_push_wr;
      r_rd_ptr <= r_rd_ptr ^ w_pop;
      r_occ    <= w_occ_nxt[1:0];
    end
  end
endmodule
